test_burst_generator: RTL and testbench
=======================================

// Module: test_burst_generator
// PURPOSE
//  Parametrised successor to the single-burst test generator. On start, reads a configurable
//  run of words from on_chip_memory and replays each word to the DUT. Runs are set by base
//  address, length and stride. Memory read latency is parametrised and the DUT can
//  backpressure through dut_ready. Supports abort and loop (repeat) mode, and reports
//  busy, done and word count. Sits between on_chip_memory and the DUT in the test harness.
// PARAMETERS
//  ADDR_WIDTH  11               on_chip_memory address width; addresses wrap mod 2**ADDR_WIDTH
//  DATA_WIDTH  16               memory word / DATA_BUS width
//  RD_LATENCY  1                cycles from rd_en high to mem_rdata valid (legal range 1..4)
//  LEN_WIDTH   ADDR_WIDTH+1     width of cfg_length and word_count
// PORTS
//  clk            in   1           single clock, rising edge
//  reset          in   1           synchronous, active-high
//  start          in   1           launch request; sampled only in IDLE
//  cfg_base_addr  in   ADDR_WIDTH  first address of the run
//  cfg_length     in   LEN_WIDTH   words per pass; 0 = empty run
//  cfg_stride     in   ADDR_WIDTH  address increment per word
//  cfg_loop       in   1           1 = restart at base after each pass until abort
//  abort          in   1           terminate the run; wins over every other event
//  address_BUS    out  ADDR_WIDTH  on_chip_memory address
//  rd_en          out  1           one-cycle memory read strobe
//  mem_rdata      in   DATA_WIDTH  memory read data, valid RD_LATENCY cycles after rd_en
//  DATA_BUS       out  DATA_WIDTH  word presented to the DUT
//  wr_en          out  1           DUT write strobe
//  chip_sel       out  1           DUT select; always equal to wr_en
//  dut_ready      in   1           DUT accepts the word in any cycle where wr_en && dut_ready
//  busy           out  1           run in progress
//  done           out  1           one-cycle pulse at the end of each pass
//  word_count     out  LEN_WIDTH   words accepted in the current pass
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0.
//    A reset asserted mid-run forces IDLE on the next edge, with no done pulse.
//  - States: IDLE, READ_REQ, WAIT_READ, WRITE_DUT, NEXT, DONE.
//  - Configuration capture: cfg_* are captured when start is sampled high in IDLE
//    (call this cycle T). cfg_* changes after T are ignored. start is ignored outside IDLE.
//  - Empty run: cfg_length==0 goes IDLE->DONE. done=1 at T+1; rd_en never asserts.
//  - Read: READ_REQ drives rd_en=1 for exactly one cycle, with address_BUS=current address.
//    The first read occurs at T+1.
//  - Wait: WAIT_READ counts RD_LATENCY cycles. mem_rdata is captured in the cycle the
//    counter expires. A RD_LATENCY-deep valid shift register aligns the capture.
//  - Write: WRITE_DUT holds wr_en=chip_sel=1 with DATA_BUS=captured word. All three stay
//    stable until dut_ready is sampled high; no new rd_en is issued while waiting.
//  - Timing with dut_ready=1: the write is at rd_en cycle + RD_LATENCY + 1.
//    The next rd_en follows the accept cycle, so the word period is RD_LATENCY+2 cycles.
//  - Address step: in NEXT, address <= address + cfg_stride (mod 2**ADDR_WIDTH) and word_count
//    increments. The transition is to DONE when word_count reaches cfg_length, else to READ_REQ.
//  - DONE: lasts one cycle with done=1 and busy=0.
//    If cfg_loop=1, the next state is READ_REQ with address=base and word_count=0
//    (busy returns high); otherwise the next state is IDLE.
//  - busy: 1 in READ_REQ, WAIT_READ, WRITE_DUT and NEXT; 0 in IDLE and DONE.
//  - abort: when sampled high in any non-IDLE state, the next state is IDLE.
//    rd_en, wr_en and chip_sel are 0 and busy=0 from the next cycle; no done pulse.
//    Any in-flight read data is discarded.
//  - word_count: cleared at T and in loop-mode DONE; holds its value in IDLE after a run.
// STRUCTURE
//  - Package test_gen_pkg holds gen_state_t (logic [2:0] enum) and MAX_RD_LATENCY=4.
//  - Sub-module tg_read_pipe: RD_LATENCY-deep valid shift register; its output pulse
//    triggers the mem_rdata capture. All other logic lives in one FSM + datapath.
// TESTING
//  1. ADDR_WIDTH=11, RD_LATENCY=1, base=0, len=8, stride=1, dut_ready=1
//     -> address_BUS 0..7, one rd_en each, wr_en every 3 cycles with DATA_BUS=mem[i],
//        done at T+25, word_count=8.
//  2. base=2045, len=4, stride=3 -> addresses 2045, 0, 3, 6 (wrap checked); done after word 4.
//  3. dut_ready low for 5 cycles during word 2
//     -> wr_en, chip_sel and DATA_BUS held stable, no rd_en, word_count frozen;
//        resumes on the accept cycle.
//  4. len=0 -> no rd_en or wr_en, done=1 at T+1 only, busy stays 0.
//     start asserted while busy is ignored.
//  5. abort during the WAIT_READ of word 3 -> IDLE next cycle, strobes 0, no done.
//     A new start then runs cleanly. Repeat with reset instead of abort: all outputs 0.
//  6. cfg_loop=1, base=16, len=2, RD_LATENCY=3
//     -> addresses 16,17,16,17,..., done pulse per pass, word_count 0->2 per pass,
//        abort stops the run.

Source files
------------

// File: rtl/test_gen_pkg.sv
// Shared types and limits for the burst test generator.
// The state encoding and the read-latency ceiling live here so the FSM and pipe agree.
package test_gen_pkg;

    localparam int MAX_RD_LATENCY = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_REQ  = 3'd1,
        WAIT_READ = 3'd2,
        WRITE_DUT = 3'd3,
        NEXT      = 3'd4,
        DONE      = 3'd5
    } gen_state_t;

endpackage

// File: rtl/tg_read_pipe.sv
// Valid shift register that tracks an outstanding memory read.
// out_valid pulses exactly DEPTH cycles after in_valid, marking when read data is valid.
module tg_read_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] valid_sr;

    // A flush drops any read still in flight so stale data is never captured.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];

endmodule

// File: rtl/test_burst_generator.sv
// Replays a configurable run of on_chip_memory words to the DUT.
// Supports base/length/stride, parametrised read latency, DUT backpressure, abort and loop mode.
module test_burst_generator
    import test_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_length,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic                  cfg_loop,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] address_BUS,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] DATA_BUS,
    output logic                  wr_en,
    output logic                  chip_sel,
    input  logic                  dut_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  word_count
);

    localparam int PIPE_DEPTH = (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                                (RD_LATENCY < 1) ? 1 : RD_LATENCY;

    gen_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0] base_q, stride_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  loop_q;
    logic                  rd_valid, kill, accept, last_word;

    assign kill      = abort && (state != IDLE);
    assign accept    = (state == WRITE_DUT) && dut_ready;
    assign last_word = (word_count + LEN_WIDTH'(1)) == len_q;

    tg_read_pipe #(.DEPTH(PIPE_DEPTH)) u_read_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (kill),
        .in_valid  (rd_en),
        .out_valid (rd_valid)
    );

    // The address/count step is taken on the accept edge itself so a word costs only
    // RD_LATENCY+2 cycles; NEXT remains a legal encoding that re-dispatches the same way.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = (cfg_length == '0) ? DONE : READ_REQ;
            READ_REQ:  state_next = WAIT_READ;
            WAIT_READ: if (rd_valid) state_next = WRITE_DUT;
            WRITE_DUT: if (dut_ready) state_next = last_word ? DONE : READ_REQ;
            NEXT:      state_next = (word_count == len_q) ? DONE : READ_REQ;
            DONE:      state_next = (loop_q && len_q != '0) ? READ_REQ : IDLE;
            default:   state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;
    end

    // Outputs are decoded from the next state so every strobe is a clean register output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            address_BUS <= '0;
            rd_en       <= 1'b0;
            DATA_BUS    <= '0;
            wr_en       <= 1'b0;
            chip_sel    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_count  <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
        end else begin
            state    <= state_next;
            rd_en    <= (state_next == READ_REQ);
            wr_en    <= (state_next == WRITE_DUT);
            chip_sel <= (state_next == WRITE_DUT);
            busy     <= state_next inside {READ_REQ, WAIT_READ, WRITE_DUT, NEXT};
            done     <= (state_next == DONE);
            if (state == IDLE && start) begin
                base_q      <= cfg_base_addr;
                stride_q    <= cfg_stride;
                len_q       <= cfg_length;
                loop_q      <= cfg_loop;
                address_BUS <= cfg_base_addr;
                word_count  <= '0;
            end
            if (state == WAIT_READ && rd_valid && !kill) begin
                DATA_BUS <= mem_rdata;
            end
            if (accept && !kill) begin
                address_BUS <= address_BUS + stride_q;
                word_count  <= word_count + LEN_WIDTH'(1);
            end
            if (state == DONE && state_next == READ_REQ) begin
                address_BUS <= base_q;
                word_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_test_burst_generator.sv
// Directed bench for test_burst_generator: one instance at RD_LATENCY=1, one at 3 for loop mode.
// Each task drives a scenario and compares cycle-exact expectations against the outputs.
module tb_test_burst_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          fails = 0;

    logic        start = 1'b0, cfg_loop = 1'b0, abort = 1'b0, dut_ready = 1'b1;
    logic [10:0] cfg_base_addr = '0, cfg_stride = '0;
    logic [11:0] cfg_length = '0;
    logic [10:0] address_a;
    logic [15:0] rdata_a, data_a;
    logic        rd_en_a, wr_en_a, cs_a, busy_a, done_a;
    logic [11:0] count_a;

    logic        start_b = 1'b0, loop_b = 1'b0, abort_b = 1'b0;
    logic [10:0] base_b = '0, stride_b = '0;
    logic [11:0] len_b = '0;
    logic [10:0] address_b;
    logic [15:0] rdata_b, data_b, d1_b, d2_b;
    logic        rd_en_b, wr_en_b, cs_b, busy_b, done_b;
    logic [11:0] count_b;

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [10:0] a);
        return 16'hC3A5 ^ {a, a[4:0]};
    endfunction

    // Memory models: a garbage word is returned whenever no read was issued.
    always @(posedge clk) rdata_a <= rd_en_a ? memf(address_a) : 16'hDEAD;
    always @(posedge clk) begin
        d1_b    <= rd_en_b ? memf(address_b) : 16'hDEAD;
        d2_b    <= d1_b;
        rdata_b <= d2_b;
    end

    test_burst_generator #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .RD_LATENCY(1), .LEN_WIDTH(12)) dut_a (
        .clk(clk), .reset(reset), .start(start), .cfg_base_addr(cfg_base_addr),
        .cfg_length(cfg_length), .cfg_stride(cfg_stride), .cfg_loop(cfg_loop), .abort(abort),
        .address_BUS(address_a), .rd_en(rd_en_a), .mem_rdata(rdata_a), .DATA_BUS(data_a),
        .wr_en(wr_en_a), .chip_sel(cs_a), .dut_ready(dut_ready), .busy(busy_a), .done(done_a),
        .word_count(count_a)
    );

    test_burst_generator #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .RD_LATENCY(3), .LEN_WIDTH(12)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cfg_base_addr(base_b),
        .cfg_length(len_b), .cfg_stride(stride_b), .cfg_loop(loop_b), .abort(abort_b),
        .address_BUS(address_b), .rd_en(rd_en_b), .mem_rdata(rdata_b), .DATA_BUS(data_b),
        .wr_en(wr_en_b), .chip_sel(cs_b), .dut_ready(1'b1), .busy(busy_b), .done(done_b),
        .word_count(count_b)
    );

    // Returns 1 ns into cycle T+1; configuration is scrambled right after capture.
    task automatic launch(input logic [10:0] b, input logic [11:0] l, input logic [10:0] s, input logic lp);
        @(posedge clk); #1;
        cfg_base_addr = b; cfg_length = l; cfg_stride = s; cfg_loop = lp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_base_addr = ~b; cfg_length = 12'd3; cfg_stride = 11'd7; cfg_loop = ~lp;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({address_a, rd_en_a, data_a, wr_en_a, cs_a, busy_a, done_a, count_a} !== '0) begin fails++; $display("FAIL reset_outputs_a: got %h want 0", {address_a, rd_en_a, data_a, wr_en_a, cs_a, busy_a, done_a, count_a}); end
        checks++; if ({rd_en_b, wr_en_b, busy_b, done_b, count_b} !== '0) begin fails++; $display("FAIL reset_outputs_b: got %h want 0", {rd_en_b, wr_en_b, busy_b, done_b, count_b}); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_burst();
        logic exp_rd, exp_wr;
        launch(11'd0, 12'd8, 11'd1, 1'b0);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            exp_rd = (k <= 22) && (k % 3 == 1);
            exp_wr = (k >= 3) && (k <= 24) && (k % 3 == 0);
            checks++; if (rd_en_a !== exp_rd) begin fails++; $display("FAIL basic_rd_en k=%0d: got %b want %b", k, rd_en_a, exp_rd); end
            checks++; if (wr_en_a !== exp_wr) begin fails++; $display("FAIL basic_wr_en k=%0d: got %b want %b", k, wr_en_a, exp_wr); end
            checks++; if (cs_a !== exp_wr) begin fails++; $display("FAIL basic_chip_sel k=%0d: got %b want %b", k, cs_a, exp_wr); end
            checks++; if (busy_a !== (k <= 24)) begin fails++; $display("FAIL basic_busy k=%0d: got %b want %b", k, busy_a, (k <= 24)); end
            checks++; if (done_a !== (k == 25)) begin fails++; $display("FAIL basic_done k=%0d: got %b want %b", k, done_a, (k == 25)); end
            checks++; if (count_a !== 12'((k - 1) / 3 > 8 ? 8 : (k - 1) / 3)) begin fails++; $display("FAIL basic_word_count k=%0d: got %0d", k, count_a); end
            if (exp_rd) begin
                checks++; if (address_a !== 11'((k - 1) / 3)) begin fails++; $display("FAIL basic_address k=%0d: got %0d want %0d", k, address_a, (k - 1) / 3); end
            end
            if (exp_wr) begin
                checks++; if (data_a !== memf(11'((k - 3) / 3))) begin fails++; $display("FAIL basic_data k=%0d: got %h want %h", k, data_a, memf(11'((k - 3) / 3))); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [10:0] exp_a [4];
        int nrd = 0, nwr = 0, done_k = 0;
        exp_a = '{11'd2045, 11'd0, 11'd3, 11'd6};
        launch(11'd2045, 12'd4, 11'd3, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rd_en_a) begin
                checks++;
                if (nrd >= 4) begin fails++; $display("FAIL wrap_extra_read: got read %0d want 4 reads", nrd + 1); end
                else if (address_a !== exp_a[nrd]) begin fails++; $display("FAIL wrap_address[%0d]: got %0d want %0d", nrd, address_a, exp_a[nrd]); end
                nrd++;
            end
            if (wr_en_a && nwr < 4) begin
                checks++; if (data_a !== memf(exp_a[nwr])) begin fails++; $display("FAIL wrap_data[%0d]: got %h want %h", nwr, data_a, memf(exp_a[nwr])); end
                nwr++;
            end
            if (done_a) begin done_k = k; break; end
            @(posedge clk); #1;
        end
        checks++; if (done_k != 13) begin fails++; $display("FAIL wrap_done_cycle: got %0d want 13", done_k); end
        checks++; if (nrd != 4 || nwr != 4) begin fails++; $display("FAIL wrap_word_total: got %0d/%0d want 4/4", nrd, nwr); end
        checks++; if (count_a !== 12'd4) begin fails++; $display("FAIL wrap_word_count: got %0d want 4", count_a); end
    endtask

    task automatic test_backpressure();
        launch(11'd100, 12'd4, 11'd1, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            dut_ready = !(k >= 6 && k <= 10);
            @(negedge clk);
            if (k >= 6 && k <= 11) begin
                checks++; if ({wr_en_a, cs_a, rd_en_a} !== 3'b110) begin fails++; $display("FAIL stall_strobes k=%0d: got %b want 110", k, {wr_en_a, cs_a, rd_en_a}); end
                checks++; if (data_a !== memf(11'd101)) begin fails++; $display("FAIL stall_data k=%0d: got %h want %h", k, data_a, memf(11'd101)); end
                checks++; if (count_a !== 12'd1) begin fails++; $display("FAIL stall_word_count k=%0d: got %0d want 1", k, count_a); end
            end
            if (k == 12) begin
                checks++; if (!rd_en_a || address_a !== 11'd102 || count_a !== 12'd2) begin fails++; $display("FAIL stall_resume: got rd=%b addr=%0d cnt=%0d want 1/102/2", rd_en_a, address_a, count_a); end
            end
            checks++; if (done_a !== (k == 18)) begin fails++; $display("FAIL stall_done k=%0d: got %b want %b", k, done_a, (k == 18)); end
            @(posedge clk); #1;
        end
        dut_ready = 1'b1;
        checks++; if (count_a !== 12'd4) begin fails++; $display("FAIL stall_final_count: got %0d want 4", count_a); end
    endtask

    task automatic test_empty_and_busy_start();
        launch(11'd40, 12'd0, 11'd1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (done_a !== (k == 1)) begin fails++; $display("FAIL empty_done k=%0d: got %b want %b", k, done_a, (k == 1)); end
            checks++; if ({busy_a, rd_en_a, wr_en_a} !== 3'b000) begin fails++; $display("FAIL empty_strobes k=%0d: got %b want 000", k, {busy_a, rd_en_a, wr_en_a}); end
            checks++; if (count_a !== 12'd0) begin fails++; $display("FAIL empty_word_count k=%0d: got %0d want 0", k, count_a); end
            @(posedge clk); #1;
        end
        launch(11'd50, 12'd3, 11'd2, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k >= 2 && k <= 5) begin start = 1'b1; cfg_base_addr = 11'd999; cfg_length = 12'd0; end
            else start = 1'b0;
            @(negedge clk);
            if (k == 4 || k == 7) begin
                checks++; if (!rd_en_a || address_a !== (k == 4 ? 11'd52 : 11'd54)) begin fails++; $display("FAIL busy_start_addr k=%0d: got rd=%b addr=%0d", k, rd_en_a, address_a); end
            end
            checks++; if (done_a !== (k == 10)) begin fails++; $display("FAIL busy_start_done k=%0d: got %b want %b", k, done_a, (k == 10)); end
            if (k == 11) begin
                checks++; if (busy_a !== 1'b0 || count_a !== 12'd3) begin fails++; $display("FAIL busy_start_end: got busy=%b cnt=%0d want 0/3", busy_a, count_a); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort_reset();
        launch(11'd0, 12'd8, 11'd1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            abort = (k == 8);
            @(negedge clk);
            checks++; if (done_a !== 1'b0) begin fails++; $display("FAIL abort_done k=%0d: got %b want 0", k, done_a); end
            if (k >= 9) begin
                checks++; if ({rd_en_a, wr_en_a, cs_a, busy_a} !== 4'b0000) begin fails++; $display("FAIL abort_strobes k=%0d: got %b want 0000", k, {rd_en_a, wr_en_a, cs_a, busy_a}); end
                checks++; if (count_a !== 12'd2) begin fails++; $display("FAIL abort_word_count k=%0d: got %0d want 2", k, count_a); end
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        launch(11'd200, 12'd2, 11'd5, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1 || k == 4) begin
                checks++; if (!rd_en_a || address_a !== (k == 1 ? 11'd200 : 11'd205)) begin fails++; $display("FAIL restart_addr k=%0d: got rd=%b addr=%0d", k, rd_en_a, address_a); end
            end
            if (k == 3 || k == 6) begin
                checks++; if (!wr_en_a || data_a !== memf(k == 3 ? 11'd200 : 11'd205)) begin fails++; $display("FAIL restart_data k=%0d: got wr=%b data=%h", k, wr_en_a, data_a); end
            end
            checks++; if (done_a !== (k == 7)) begin fails++; $display("FAIL restart_done k=%0d: got %b want %b", k, done_a, (k == 7)); end
            @(posedge clk); #1;
        end
        checks++; if (count_a !== 12'd2) begin fails++; $display("FAIL restart_word_count: got %0d want 2", count_a); end
        launch(11'd0, 12'd8, 11'd1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            reset = (k == 8);
            @(negedge clk);
            if (k >= 9) begin
                checks++; if ({address_a, rd_en_a, data_a, wr_en_a, cs_a, busy_a, done_a, count_a} !== '0) begin fails++; $display("FAIL midrun_reset k=%0d: got %h want 0", k, {address_a, rd_en_a, data_a, wr_en_a, cs_a, busy_a, done_a, count_a}); end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_loop();
        int j;
        @(posedge clk); #1;
        base_b = 11'd16; len_b = 12'd2; stride_b = 11'd1; loop_b = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; base_b = 11'd300; len_b = 12'd5; stride_b = 11'd9; loop_b = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            abort_b = (k == 34);
            @(negedge clk);
            j = (k - 1) % 11 + 1;
            if (k <= 34) begin
                checks++; if (rd_en_b !== (j == 1 || j == 6)) begin fails++; $display("FAIL loop_rd_en k=%0d: got %b", k, rd_en_b); end
                checks++; if (wr_en_b !== (j == 5 || j == 10)) begin fails++; $display("FAIL loop_wr_en k=%0d: got %b", k, wr_en_b); end
                checks++; if (done_b !== (j == 11) || busy_b !== (j != 11)) begin fails++; $display("FAIL loop_done_busy k=%0d: got %b%b", k, done_b, busy_b); end
                checks++; if (count_b !== (j <= 5 ? 12'd0 : j <= 10 ? 12'd1 : 12'd2)) begin fails++; $display("FAIL loop_word_count k=%0d: got %0d", k, count_b); end
                if (j == 1 || j == 6) begin
                    checks++; if (address_b !== (j == 1 ? 11'd16 : 11'd17)) begin fails++; $display("FAIL loop_address k=%0d: got %0d", k, address_b); end
                end
                if (j == 5 || j == 10) begin
                    checks++; if (data_b !== memf(j == 5 ? 11'd16 : 11'd17)) begin fails++; $display("FAIL loop_data k=%0d: got %h", k, data_b); end
                end
            end else begin
                checks++; if ({rd_en_b, wr_en_b, cs_b, busy_b, done_b} !== 5'b0) begin fails++; $display("FAIL loop_abort k=%0d: got %b want 00000", k, {rd_en_b, wr_en_b, cs_b, busy_b, done_b}); end
            end
            @(posedge clk); #1;
        end
        abort_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_wrap();
        test_backpressure();
        test_empty_and_busy_start();
        test_abort_reset();
        test_loop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
